// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: queues ALU commands, issues them one at a time to a registered ALU and holds each result for downstream
module alu_cmd_issuer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [15:0]      CMD_A,
  input  logic [15:0]      CMD_B,
  input  logic [3:0]       CMD_FUN,
  output logic [15:0]      ALU_A,
  output logic [15:0]      ALU_B,
  output logic [3:0]       ALU_FUN,
  input  logic [15:0]      ALU_RES,
  input  logic [4:0]       ALU_FLAGS,
  output logic             RES_VALID,
  input  logic             RES_READY,
  output logic [15:0]      RES_DATA,
  output logic [4:0]       RES_FLAGS,
  output logic [PTR_W:0]   FIFO_COUNT
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HOLD = 2'd3;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
  logic [35:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [1:0]       r_state;
  logic             r_res_valid;
  logic [15:0]      r_res_data;
  logic [4:0]       r_res_flags;
  logic [15:0]      r_alu_a;
  logic [15:0]      r_alu_b;
  logic [3:0]       r_alu_fun;
  logic             w_push;
  logic             w_pop;
  assign CMD_READY = r_count != FULL;
  assign w_push = CMD_VALID && CMD_READY;
  assign w_pop = (r_count != '0) && (r_state == IDLE || (r_state == HOLD && RES_READY));
  assign ALU_A = r_alu_a;
  assign ALU_B = r_alu_b;
  assign ALU_FUN = r_alu_fun;
  assign RES_VALID = r_res_valid;
  assign RES_DATA = r_res_data;
  assign RES_FLAGS = r_res_flags;
  assign FIFO_COUNT = r_count;
  // command storage; no reset needed because the count gates every read
  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr_ptr] <= {CMD_A, CMD_B, CMD_FUN};
  end
  // queue pointers and occupancy; a push into an empty queue is popped one cycle later
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push != w_pop) r_count <= w_push ? r_count + (PTR_W+1)'(1) : r_count - (PTR_W+1)'(1);
    end
  end
  // issue sequencer: pop -> ALU samples -> capture result -> hold until accepted
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_res_valid <= 1'b0;
      r_res_data <= '0;
      r_res_flags <= '0;
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_alu_fun <= 4'b1111;
    end else begin
      if (w_pop) {r_alu_a, r_alu_b, r_alu_fun} <= r_mem[r_rd_ptr];
      case (r_state)
        IDLE: r_state <= w_pop ? ISSUE : IDLE;
        ISSUE: r_state <= CAPTURE;
        CAPTURE: begin
          r_res_data <= ALU_RES;
          r_res_flags <= ALU_FLAGS;
          r_res_valid <= 1'b1;
          r_state <= HOLD;
        end
        default: begin
          if (RES_READY) begin
            r_res_valid <= 1'b0;
            r_state <= w_pop ? ISSUE : IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: vector table, directed corner sequences and random traffic against a result scoreboard
module tb_alu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic CMD_VALID = 1'b0;
  logic RES_READY = 1'b0;
  logic [15:0] CMD_A = '0;
  logic [15:0] CMD_B = '0;
  logic [3:0] CMD_FUN = '0;
  logic CMD_READY, RES_VALID;
  logic [15:0] ALU_A, ALU_B, ALU_RES, RES_DATA;
  logic [3:0] ALU_FUN;
  logic [4:0] ALU_FLAGS, RES_FLAGS;
  logic [PTR_W:0] FIFO_COUNT;
  int n_chk = 0;
  int n_pass = 0;
  int hs_cnt = 0;
  logic [20:0] expq[$];
  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0] fun;
    logic [15:0] res;
    logic [4:0] flg;
  } vec_t;
  vec_t vecs[12];

  alu_cmd_issuer #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_FUN(CMD_FUN),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
    .ALU_RES(ALU_RES), .ALU_FLAGS(ALU_FLAGS),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_DATA(RES_DATA), .RES_FLAGS(RES_FLAGS), .FIFO_COUNT(FIFO_COUNT)
  );

  always #5 CLK = ~CLK;

  // behavioural ALU_16B: returns {result, Carry, Arith, Logic, CMP, Shift}
  function automatic logic [20:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    logic [16:0] s;
    logic [31:0] p;
    p = a * b;
    case (f)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; return {s[15:0], s[16], 4'b1000}; end
      4'd1: begin s = {1'b0, a} - {1'b0, b}; return {s[15:0], s[16], 4'b1000}; end
      4'd2: return {p[15:0], 5'b01000};
      4'd3: return {(b == 16'd0) ? 16'd0 : a / b, 5'b01000};
      4'd4: return {a & b, 5'b00100};
      4'd5: return {a | b, 5'b00100};
      4'd6: return {~(a & b), 5'b00100};
      4'd7: return {~(a | b), 5'b00100};
      4'd8: return {a ^ b, 5'b00100};
      4'd9: return {~(a ^ b), 5'b00100};
      4'd10: return {(a == b) ? 16'd1 : 16'd0, 5'b00010};
      4'd11: return {(a > b) ? 16'd2 : 16'd0, 5'b00010};
      4'd12: return {(a < b) ? 16'd3 : 16'd0, 5'b00010};
      4'd13: return {1'b0, a[15:1], 5'b00001};
      4'd14: return {a[14:0], 1'b0, 5'b00001};
      default: return 21'd0;
    endcase
  endfunction

  // the ALU's one-clock output register
  always_ff @(posedge CLK) {ALU_RES, ALU_FLAGS} <= alu_f(ALU_A, ALU_B, ALU_FUN);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  // advance one edge; scoreboard accepted commands and delivered results in order
  task automatic step();
    logic acc, hs, rst_e;
    logic [20:0] cmd_res, got;
    acc = CMD_VALID && CMD_READY && !RST;
    hs = RES_VALID && RES_READY && !RST;
    rst_e = RST;
    cmd_res = alu_f(CMD_A, CMD_B, CMD_FUN);
    got = {RES_DATA, RES_FLAGS};
    @(posedge CLK);
    #1;
    if (rst_e) expq.delete();
    if (hs) begin
      hs_cnt++;
      check("result_expected", 32'(expq.size() != 0), 1);
      if (expq.size() != 0) check("result_order", got, expq.pop_front());
    end
    if (acc) expq.push_back(cmd_res);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    CMD_VALID = 1'b0;
    RES_READY = 1'b0;
    step();
    step();
    RST = 1'b0;
  endtask

  task automatic set_cmd(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f);
    CMD_VALID = 1'b1;
    CMD_A = a;
    CMD_B = b;
    CMD_FUN = f;
  endtask

  task automatic drain(input string nm);
    CMD_VALID = 1'b0;
    RES_READY = 1'b1;
    for (int i = 0; i < 200 && (expq.size() != 0 || RES_VALID); i++) step();
    check(nm, 32'(expq.size()), 0);
  endtask

  initial begin
    logic [15:0] mix_res[3];
    logic [4:0] mix_flg[3];
    int t[3];
    int seen, cyc, hs_base, bad;
    logic [20:0] r1;
    vecs[0] = '{16'h0005, 16'h0004, 4'b0000, 16'h0009, 5'b01000};
    vecs[1] = '{16'h0005, 16'h0004, 4'b0010, 16'h0014, 5'b01000};
    vecs[2] = '{16'h0005, 16'h0004, 4'b1011, 16'h0002, 5'b00010};
    vecs[3] = '{16'hAAC5, 16'h0004, 4'b1101, 16'h5562, 5'b00001};
    vecs[4] = '{16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 5'b11000};
    vecs[5] = '{16'h0003, 16'h0005, 4'b0001, 16'hFFFE, 5'b11000};
    vecs[6] = '{16'h00F0, 16'h0FF0, 4'b0100, 16'h00F0, 5'b00100};
    vecs[7] = '{16'h00F0, 16'h0F0F, 4'b0101, 16'h0FFF, 5'b00100};
    vecs[8] = '{16'h1234, 16'h1234, 4'b1010, 16'h0001, 5'b00010};
    vecs[9] = '{16'h8001, 16'h0000, 4'b1110, 16'h0002, 5'b00001};
    vecs[10] = '{16'h1234, 16'h5678, 4'b1111, 16'h0000, 5'b00000};
    vecs[11] = '{16'd100, 16'd7, 4'b0011, 16'h000E, 5'b01000};
    mix_res = '{16'h0014, 16'h0002, 16'h5562};
    mix_flg = '{5'b01000, 5'b00010, 5'b00001};

    do_reset();
    check("rst_res_valid", RES_VALID, 0);
    check("rst_res_data", RES_DATA, 0);
    check("rst_res_flags", RES_FLAGS, 0);
    check("rst_alu_a", ALU_A, 0);
    check("rst_alu_b", ALU_B, 0);
    check("rst_alu_fun", ALU_FUN, 4'hF);
    check("rst_count", FIFO_COUNT, 0);
    check("rst_cmd_ready", CMD_READY, 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ALU_FUN !== 4'hF || RES_VALID !== 1'b0) bad++;
    end
    check("idle_quiet", bad, 0);

    RES_READY = 1'b1;
    foreach (vecs[i]) begin
      set_cmd(vecs[i].a, vecs[i].b, vecs[i].fun);
      step();
      CMD_VALID = 1'b0;
      check("vec_e0_count", FIFO_COUNT, 1);
      step();
      check("vec_e1_count", FIFO_COUNT, 0);
      check("vec_e1_alu_a", ALU_A, vecs[i].a);
      check("vec_e1_alu_b", ALU_B, vecs[i].b);
      check("vec_e1_alu_fun", ALU_FUN, vecs[i].fun);
      step();
      check("vec_e2_valid", RES_VALID, 0);
      step();
      check("vec_e3_valid", RES_VALID, 1);
      check("vec_e3_data", RES_DATA, vecs[i].res);
      check("vec_e3_flags", RES_FLAGS, vecs[i].flg);
      step();
      check("vec_e4_valid", RES_VALID, 0);
    end

    set_cmd(16'h0005, 16'h0004, 4'b0010);
    step();
    set_cmd(16'h0005, 16'h0004, 4'b1011);
    step();
    set_cmd(16'hAAC5, 16'h0004, 4'b1101);
    step();
    CMD_VALID = 1'b0;
    cyc = 2;
    seen = 0;
    while (seen < 3 && cyc < 40) begin
      step();
      cyc++;
      if (RES_VALID) begin
        t[seen] = cyc;
        check("mix_data", RES_DATA, mix_res[seen]);
        check("mix_flags", RES_FLAGS, mix_flg[seen]);
        seen++;
      end
    end
    check("mix_results_seen", seen, 3);
    check("mix_first_latency", t[0], 3);
    check("mix_gap1", t[1] - t[0], 3);
    check("mix_gap2", t[2] - t[1], 3);
    drain("mix_drained");

    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_cmd(16'(i * 16'h0111 + 1), 16'(i + 2), 4'(i));
      if (i == 0) r1 = alu_f(CMD_A, CMD_B, CMD_FUN);
      step();
    end
    check("full_cmd_ready", CMD_READY, 0);
    check("full_count", FIFO_COUNT, 4);
    check("full_res_valid", RES_VALID, 1);
    check("full_res_first", {RES_DATA, RES_FLAGS}, r1);
    set_cmd(16'h7777, 16'h0003, 4'b0001);
    for (int i = 0; i < 3; i++) step();
    check("full_hold_count", FIFO_COUNT, 4);
    check("full_hold_ready", CMD_READY, 0);
    check("full_hold_data", {RES_DATA, RES_FLAGS}, r1);
    hs_base = hs_cnt;
    RES_READY = 1'b1;
    step();
    check("full_pop_ready", CMD_READY, 1);
    check("full_pop_count", FIFO_COUNT, 3);
    step();
    check("full_sixth_count", FIFO_COUNT, 4);
    drain("full_drained");
    check("full_result_total", hs_cnt - hs_base, 6);

    do_reset();
    set_cmd(16'h0101, 16'h0011, 4'b0000);
    step();
    set_cmd(16'h0202, 16'h0022, 4'b0001);
    step();
    set_cmd(16'h0303, 16'h0033, 4'b1000);
    step();
    CMD_VALID = 1'b0;
    step();
    check("wrap_pre_count", FIFO_COUNT, 2);
    check("wrap_pre_valid", RES_VALID, 1);
    RES_READY = 1'b1;
    set_cmd(16'h0404, 16'h0044, 4'b0101);
    step();
    check("wrap_pushpop_count", FIFO_COUNT, 2);
    set_cmd(16'h0505, 16'h0055, 4'b1100);
    step();
    check("wrap_post_count", FIFO_COUNT, 3);
    drain("wrap_drained");

    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_cmd(16'(16'h1000 + i), 16'h0002, 4'b0010);
      step();
    end
    CMD_VALID = 1'b0;
    RES_READY = 1'b1;
    step();
    RES_READY = 1'b0;
    step();
    check("midrst_pre_count", FIFO_COUNT, 3);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("midrst_count", FIFO_COUNT, 0);
    check("midrst_valid", RES_VALID, 0);
    check("midrst_ready", CMD_READY, 1);
    RES_READY = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (RES_VALID !== 1'b0) bad++;
    end
    check("midrst_no_stale", bad, 0);
    set_cmd(16'h0030, 16'h0012, 4'b0001);
    step();
    CMD_VALID = 1'b0;
    step();
    step();
    check("midrst_e2_valid", RES_VALID, 0);
    step();
    check("midrst_e3_valid", RES_VALID, 1);
    check("midrst_e3_data", RES_DATA, 16'h001E);
    check("midrst_e3_flags", RES_FLAGS, 5'b01000);
    step();

    do_reset();
    bad = 0;
    for (int i = 0; i < 1500; i++) begin
      CMD_VALID = 1'($urandom_range(0, 1));
      CMD_A = 16'($urandom);
      CMD_B = 16'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      CMD_FUN = 4'($urandom_range(0, 15));
      RES_READY = $urandom_range(0, 3) != 0;
      step();
      if (FIFO_COUNT > 3'(DEPTH)) bad++;
    end
    check("rand_count_range", bad, 0);
    drain("rand_drained");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
